// File: rtl/dlx_hazard_unit.sv
// dlx_hazard_unit
//   Pipeline hazard controller for the DLX integer pipeline. Sits beside
//   decode, keeps a shadow of the EX/MEM/WB stages and produces:
//     - load-use stalls for a configurable load latency,
//     - EX operand forwarding selects,
//     - a multi-slot kill window after a taken branch/jump in ID.
//
//   Parameters
//     REG_BITS    register specifier width (register 0 is hardwired zero)
//     LOAD_LAT    extra cycles after EX before load data is forwardable (1..2)
//     BRANCH_KILL slots squashed after a taken branch/jump (0..3)
//
//   Ports
//     clk, reset        clock, asynchronous active-high reset
//     id_valid          ID holds a real instruction
//     id_rs1/id_rs2     ID source specifiers
//     id_uses_rs1/rs2   ID instruction actually reads that source
//     id_rd, id_reg_wr  ID destination and its write enable
//     id_is_load        ID instruction is a load
//     id_branch_taken   ID resolved a taken branch/jump this cycle
//     stall             hold PC and IF/ID, bubble into EX
//     kill              instruction in ID is squashed (enters EX invalid)
//     fwd_rs1/fwd_rs2   EX operand select: 00 regfile, 01 EX/MEM, 10 MEM/WB
//
//   Optional build macro HAZARD_PERF_CNT_EN adds saturating 32-bit
//   stall_cycles / kill_cycles counters as extra outputs.
module dlx_hazard_unit #(
  parameter int REG_BITS    = 5,
  parameter int LOAD_LAT    = 1,
  parameter int BRANCH_KILL = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                id_valid,
  input  logic [REG_BITS-1:0] id_rs1,
  input  logic [REG_BITS-1:0] id_rs2,
  input  logic                id_uses_rs1,
  input  logic                id_uses_rs2,
  input  logic [REG_BITS-1:0] id_rd,
  input  logic                id_reg_wr,
  input  logic                id_is_load,
  input  logic                id_branch_taken,
  output logic                stall,
  output logic                kill,
  output logic [1:0]          fwd_rs1,
  output logic [1:0]          fwd_rs2
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]         stall_cycles,
  output logic [31:0]         kill_cycles
`endif
);

  typedef logic [REG_BITS-1:0] reg_t;

  // A producer/consumer pair is a hazard only if the producer is live and
  // writes a non-zero register that the consumer really reads.
  function automatic logic src_hit(input logic pv, input logic pwr, input reg_t prd,
                                   input reg_t src, input logic use_src);
    return pv & pwr & use_src & (src != '0) & (prd == src);
  endfunction

`ifdef HAZARD_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction
`endif

  // Shadow valids are control state and are reset; the rest is data that
  // is only ever consumed qualified by its valid.
  logic vld_p0, vld_p1, vld_p2;
  reg_t rd_p0, rs1_p0, rs2_p0;
  logic wr_p0, ld_p0, use1_p0, use2_p0;
  // Past EX only the destination side matters: sources are never compared
  // again once an instruction has left EX.
  reg_t rd_p1, rd_p2;
  logic wr_p1, ld_p1, wr_p2;

  logic ld_hit_ex, ld_hit_mem;

  assign ld_hit_ex  = ld_p0 &
                      (src_hit(vld_p0, wr_p0, rd_p0, id_rs1, id_uses_rs1) |
                       src_hit(vld_p0, wr_p0, rd_p0, id_rs2, id_uses_rs2));
  // With a two-cycle load the value is still not forwardable while the load
  // sits in MEM, so the consumer must wait one more cycle.
  assign ld_hit_mem = (LOAD_LAT == 2) & ld_p1 &
                      (src_hit(vld_p1, wr_p1, rd_p1, id_rs1, id_uses_rs1) |
                       src_hit(vld_p1, wr_p1, rd_p1, id_rs2, id_uses_rs2));

  // kill masks stall: a squashed instruction has no operands worth waiting for.
  assign stall = id_valid & ~kill & (ld_hit_ex | ld_hit_mem);

  // Forwarding for the instruction in EX. A load in MEM is never a 01
  // source; the stall above guarantees the consumer reaches EX late enough
  // to pick it up from WB instead. MEM is younger and wins over WB.
  always_comb begin
    fwd_rs1 = 2'b00;
    fwd_rs2 = 2'b00;
    if (src_hit(vld_p1, wr_p1 & ~ld_p1, rd_p1, rs1_p0, vld_p0 & use1_p0))
      fwd_rs1 = 2'b01;
    else if (src_hit(vld_p2, wr_p2, rd_p2, rs1_p0, vld_p0 & use1_p0))
      fwd_rs1 = 2'b10;
    if (src_hit(vld_p1, wr_p1 & ~ld_p1, rd_p1, rs2_p0, vld_p0 & use2_p0))
      fwd_rs2 = 2'b01;
    else if (src_hit(vld_p2, wr_p2, rd_p2, rs2_p0, vld_p0 & use2_p0))
      fwd_rs2 = 2'b10;
  end

  // ID -> EX (p0) -> MEM (p1) -> WB (p2) boundary: valids
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p0 <= id_valid & ~kill & ~stall;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  // ID -> EX (p0) -> MEM (p1) -> WB (p2) boundary: data
  always_ff @(posedge clk) begin
    if (!stall) begin
      rd_p0   <= id_rd;
      rs1_p0  <= id_rs1;
      rs2_p0  <= id_rs2;
      wr_p0   <= id_reg_wr;
      ld_p0   <= id_is_load;
      use1_p0 <= id_uses_rs1;
      use2_p0 <= id_uses_rs2;
    end
    rd_p1 <= rd_p0;
    wr_p1 <= wr_p0;
    ld_p1 <= ld_p0;
    rd_p2 <= rd_p1;
    wr_p2 <= wr_p1;
  end

  generate
    if (BRANCH_KILL > 0) begin : g_kill
      localparam int KW = (BRANCH_KILL > 1) ? $clog2(BRANCH_KILL + 1) : 1;
      logic [KW-1:0] kill_cnt;
      logic          take;

      // Branches seen under stall are re-evaluated once the stall clears;
      // branches inside the window are squashed and cannot redirect.
      assign take = id_branch_taken & id_valid & ~stall & ~kill;
      assign kill = (kill_cnt != '0);

      always_ff @(posedge clk or posedge reset) begin
        if (reset)
          kill_cnt <= '0;
        else if (take)
          kill_cnt <= KW'(BRANCH_KILL);
        else if (!stall && kill_cnt != '0)
          kill_cnt <= kill_cnt - KW'(1);
      end
    end else begin : g_nokill
      assign kill = 1'b0;
    end
  endgenerate

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
      kill_cycles  <= '0;
    end else begin
      if (stall) stall_cycles <= sat_inc(stall_cycles);
      if (kill)  kill_cycles  <= sat_inc(kill_cycles);
    end
  end
`endif

endmodule

// File: tb/tb_dlx_hazard_unit.sv
// Testbench for dlx_hazard_unit. Two instances: A (LOAD_LAT=1, BRANCH_KILL=2)
// runs a table of per-cycle vectors plus reset corner cases; B (LOAD_LAT=2,
// BRANCH_KILL=1) runs a hand-written load-use and one-slot kill sequence.
module tb_dlx_hazard_unit;

  typedef struct packed {
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
    logic       br;
  } in_t;

  typedef struct packed {
    logic       sel;   // 0 = instance A, 1 = instance B
    logic       st;
    logic       kl;
    logic [1:0] f1;
    logic [1:0] f2;
    logic       fdc;   // forwarding not compared on this cycle
  } exp_t;

  typedef struct packed {
    in_t  i;
    exp_t e;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  in_t  ia, ib;
  logic stall_a, kill_a, stall_b, kill_b;
  logic [1:0] f1_a, f2_a, f1_b, f2_b;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] sc_a, kc_a, sc_b, kc_b;
`endif

  always #5 clk = ~clk;

  dlx_hazard_unit #(.REG_BITS(5), .LOAD_LAT(1), .BRANCH_KILL(2)) u_a (
    .clk(clk), .reset(reset),
    .id_valid(ia.valid), .id_rs1(ia.rs1), .id_rs2(ia.rs2),
    .id_uses_rs1(ia.u1), .id_uses_rs2(ia.u2), .id_rd(ia.rd),
    .id_reg_wr(ia.wr), .id_is_load(ia.ld), .id_branch_taken(ia.br),
    .stall(stall_a), .kill(kill_a), .fwd_rs1(f1_a), .fwd_rs2(f2_a)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(sc_a), .kill_cycles(kc_a)
`endif
  );

  dlx_hazard_unit #(.REG_BITS(5), .LOAD_LAT(2), .BRANCH_KILL(1)) u_b (
    .clk(clk), .reset(reset),
    .id_valid(ib.valid), .id_rs1(ib.rs1), .id_rs2(ib.rs2),
    .id_uses_rs1(ib.u1), .id_uses_rs2(ib.u2), .id_rd(ib.rd),
    .id_reg_wr(ib.wr), .id_is_load(ib.ld), .id_branch_taken(ib.br),
    .stall(stall_b), .kill(kill_b), .fwd_rs1(f1_b), .fwd_rs2(f2_b)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(sc_b), .kill_cycles(kc_b)
`endif
  );

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  function automatic in_t mki(input int v, input int r1, input int r2, input int u1,
                              input int u2, input int rd, input int wr, input int ld,
                              input int br);
    in_t x;
    x.valid = v[0]; x.rs1 = r1[4:0]; x.rs2 = r2[4:0]; x.u1 = u1[0]; x.u2 = u2[0];
    x.rd = rd[4:0]; x.wr = wr[0]; x.ld = ld[0]; x.br = br[0];
    return x;
  endfunction

  function automatic exp_t mke(input int sel, input int st, input int kl,
                               input int f1, input int f2, input int fdc);
    exp_t e;
    e.sel = sel[0]; e.st = st[0]; e.kl = kl[0]; e.f1 = f1[1:0]; e.f2 = f2[1:0];
    e.fdc = fdc[0];
    return e;
  endfunction

  function automatic vec_t mkv(input int v, input int r1, input int r2, input int u1,
                               input int u2, input int rd, input int wr, input int ld,
                               input int br, input int st, input int kl, input int f1,
                               input int f2);
    vec_t t;
    t.i = mki(v, r1, r2, u1, u2, rd, wr, ld, br);
    t.e = mke(0, st, kl, f1, f2, 0);
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Pop the oldest expectation and compare against the instance it names.
  task automatic compare(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, ".scoreboard_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    if (e.sel) begin
      chk({tag, ".stall"}, {31'd0, stall_b}, {31'd0, e.st});
      chk({tag, ".kill"},  {31'd0, kill_b},  {31'd0, e.kl});
      if (!e.fdc) begin
        chk({tag, ".fwd_rs1"}, {30'd0, f1_b}, {30'd0, e.f1});
        chk({tag, ".fwd_rs2"}, {30'd0, f2_b}, {30'd0, e.f2});
      end
    end else begin
      chk({tag, ".stall"}, {31'd0, stall_a}, {31'd0, e.st});
      chk({tag, ".kill"},  {31'd0, kill_a},  {31'd0, e.kl});
      if (!e.fdc) begin
        chk({tag, ".fwd_rs1"}, {30'd0, f1_a}, {30'd0, e.f1});
        chk({tag, ".fwd_rs2"}, {30'd0, f2_a}, {30'd0, e.f2});
      end
    end
  endtask

  // Drive one ID cycle just after the edge, check outputs on the falling edge.
  task automatic step(input logic sel, input in_t x, input exp_t e, input string tag);
    @(posedge clk);
    #1;
    if (sel) ib = x; else ia = x;
    sb.push_back(e);
    @(negedge clk);
    compare(tag);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".stall_a"}, {31'd0, stall_a}, 32'd0);
    chk({tag, ".kill_a"},  {31'd0, kill_a},  32'd0);
    chk({tag, ".fwd_a"},   {28'd0, f1_a, f2_a}, 32'd0);
    chk({tag, ".stall_b"}, {31'd0, stall_b}, 32'd0);
    chk({tag, ".kill_b"},  {31'd0, kill_b},  32'd0);
    chk({tag, ".fwd_b"},   {28'd0, f1_b, f2_b}, 32'd0);
  endtask

  vec_t tbl[25];
  in_t  nop;

  initial begin
    nop = '0;
    //            v rs1 rs2 u1 u2 rd wr ld br | st kl f1 f2
    tbl[0]  = mkv(1, 2, 0, 1, 0, 1, 1, 1, 0,   0, 0, 0, 0); // LW r1
    tbl[1]  = mkv(1, 1, 2, 1, 1, 3, 1, 0, 0,   1, 0, 0, 0); // ADD r3,r1,r2 stalls
    tbl[2]  = mkv(1, 1, 2, 1, 1, 3, 1, 0, 0,   0, 0, 0, 0); // ADD held, bubble in EX
    tbl[3]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 2, 0); // ADD in EX: rs1 from WB
    tbl[4]  = mkv(1, 6, 7, 1, 1, 5, 1, 0, 0,   0, 0, 0, 0); // ADD r5,r6,r7
    tbl[5]  = mkv(1, 5, 5, 1, 1, 8, 1, 0, 0,   0, 0, 0, 0); // SUB r8,r5,r5
    tbl[6]  = mkv(1, 5, 0, 1, 1, 9, 1, 0, 0,   0, 0, 1, 1); // OR r9,r5,r0; SUB in EX
    tbl[7]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 2, 0); // OR in EX
    tbl[8]  = mkv(1, 2, 0, 1, 0, 0, 1, 1, 0,   0, 0, 0, 0); // LW r0
    tbl[9]  = mkv(1, 0, 0, 1, 1, 3, 1, 0, 0,   0, 0, 0, 0); // ADD r3,r0,r0 no stall
    tbl[10] = mkv(1, 0, 0, 1, 0, 4, 1, 1, 0,   0, 0, 0, 0); // LW r4
    tbl[11] = mkv(1, 9, 4, 1, 0,10, 1, 0, 0,   0, 0, 0, 0); // rs2=r4 but unused
    tbl[12] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    tbl[13] = mkv(1, 1, 0, 1, 0, 0, 0, 0, 1,   0, 0, 0, 0); // taken BEQZ
    tbl[14] = mkv(1, 2, 0, 1, 0,12, 1, 1, 0,   0, 1, 0, 0); // slot 1 (LW r12)
    tbl[15] = mkv(1,12, 0, 1, 0,12, 1, 0, 1,   0, 1, 0, 0); // slot 2: branch ignored
    tbl[16] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0); // window closed
    tbl[17] = mkv(1,12, 0, 1, 0,13, 1, 0, 0,   0, 0, 0, 0); // reads r12
    tbl[18] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0); // killed r12 writer in WB
    tbl[19] = mkv(1, 0, 0, 0, 0,14, 1, 1, 0,   0, 0, 0, 0); // LW r14
    tbl[20] = mkv(1,14, 0, 1, 0, 0, 0, 0, 1,   1, 0, 0, 0); // BEQZ r14 under stall
    tbl[21] = mkv(1,14, 0, 1, 0, 0, 0, 0, 1,   0, 0, 0, 0); // re-evaluated, taken
    tbl[22] = mkv(1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 2, 0); // slot 1; BEQZ fwd from WB
    tbl[23] = mkv(1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0); // slot 2
    tbl[24] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);

    ia = nop;
    ib = nop;
    reset = 1'b1;
    #3;
    chk_idle("reset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_idle("after_reset");

    for (int k = 0; k < 25; k++)
      step(1'b0, tbl[k].i, tbl[k].e, $sformatf("A%0d", k));

    // Instance B, LOAD_LAT=2: load-use holds the consumer for two cycles.
    step(1'b1, mki(1, 2, 0, 1, 0, 1, 1, 1, 0), mke(1, 0, 0, 0, 0, 0), "B_lw");
    step(1'b1, mki(1, 1, 2, 1, 1, 3, 1, 0, 0), mke(1, 1, 0, 0, 0, 0), "B_add0");
    step(1'b1, mki(1, 1, 2, 1, 1, 3, 1, 0, 0), mke(1, 1, 0, 0, 0, 0), "B_add1");
    step(1'b1, mki(1, 1, 2, 1, 1, 3, 1, 0, 0), mke(1, 0, 0, 0, 0, 0), "B_add2");
    step(1'b1, nop,                            mke(1, 0, 0, 0, 0, 1), "B_nop");
    // Instance B, BRANCH_KILL=1: exactly one squashed slot.
    step(1'b1, mki(1, 0, 0, 0, 0, 0, 0, 0, 1), mke(1, 0, 0, 0, 0, 0), "B_br");
    step(1'b1, mki(1, 0, 0, 0, 0, 7, 1, 0, 0), mke(1, 0, 1, 0, 0, 0), "B_slot");
    step(1'b1, nop,                            mke(1, 0, 0, 0, 0, 0), "B_after");
    ib = nop;

    // Reset asserted in the middle of a stall.
    step(1'b0, mki(1, 2, 0, 1, 0, 1, 1, 1, 0), mke(0, 0, 0, 0, 0, 0), "R_lw");
    step(1'b0, mki(1, 1, 2, 1, 1, 3, 1, 0, 0), mke(0, 1, 0, 0, 0, 0), "R_stall");
    #2 reset = 1'b1;
    #1;
    chk("rst_stall.stall", {31'd0, stall_a}, 32'd0);
    chk("rst_stall.fwd",   {28'd0, f1_a, f2_a}, 32'd0);
    ia = nop;
    #1 reset = 1'b0;

    // Reset asserted inside a kill window.
    step(1'b0, mki(1, 0, 0, 0, 0, 0, 0, 0, 1), mke(0, 0, 0, 0, 0, 0), "R_br");
    step(1'b0, mki(1, 0, 0, 0, 0, 0, 0, 0, 0), mke(0, 0, 1, 0, 0, 0), "R_slot");
    #2 reset = 1'b1;
    #1;
    chk("rst_kill.kill",  {31'd0, kill_a},  32'd0);
    chk("rst_kill.stall", {31'd0, stall_a}, 32'd0);
    chk("rst_kill.fwd",   {28'd0, f1_a, f2_a}, 32'd0);
`ifdef HAZARD_PERF_CNT_EN
    chk("rst_kill.stall_cycles", sc_a, 32'd0);
    chk("rst_kill.kill_cycles",  kc_a, 32'd0);
`endif
    ia = nop;
    #1 reset = 1'b0;

    // Nothing from before reset may be forwarded afterwards.
    step(1'b0, mki(1, 1, 3, 1, 1, 4, 1, 0, 0), mke(0, 0, 0, 0, 0, 0), "R_add");
    step(1'b0, nop,                            mke(0, 0, 0, 0, 0, 0), "R_residual");

    // Three forced load-use stalls.
    for (int n = 0; n < 3; n++) begin
      step(1'b0, mki(1, 0, 0, 0, 0, 1, 1, 1, 0), mke(0, 0, 0, 0, 0, 1), $sformatf("P%0d_lw", n));
      step(1'b0, mki(1, 1, 2, 1, 1, 3, 1, 0, 0), mke(0, 1, 0, 0, 0, 1), $sformatf("P%0d_s", n));
      step(1'b0, mki(1, 1, 2, 1, 1, 3, 1, 0, 0), mke(0, 0, 0, 0, 0, 1), $sformatf("P%0d_go", n));
    end
`ifdef HAZARD_PERF_CNT_EN
    chk("perf.stall_cycles", sc_a, 32'd3);
    chk("perf.kill_cycles",  kc_a, 32'd0);
`endif
    ia = nop;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
